mp_add_seq: RTL and testbench
=============================

Name: mp_add_seq

Overview:
- Multi-precision add/subtract sequencer built around one shared N-bit ripple adder instance.
- Accepts two WORDS×N-bit operands in one handshake. Feeds the adder one N-bit word per clock, LSW first, with a registered carry between words.
- Returns the full-width result over a valid/ready handshake.
- Lets wide arithmetic (e.g. 16/32-bit) reuse the narrow ripple datapath.

Parameters:
- N, 4, word width of the internal ripple adder (N ≥ 2).
- WORDS, 4, number of words per operand (WORDS ≥ 1). Total width W = N*WORDS.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/command valid.
- in_ready  output  1  block can accept a command this cycle.
- a  input  W  operand A.
- b  input  W  operand B.
- sub  input  1  0 = A+B+cin; 1 = A+~B+(~cin), i.e. A−B−cin.
- cin  input  1  carry-in (add) / borrow-in (sub).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  W  result.
- cout  output  1  raw carry out of MSW. For sub, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst=1 at an edge): state IDLE, word counter 0, carry reg 0, sum=0, cout=0, ovf=0, out_valid=0. in_ready=1 in the cycle after reset deasserts. Reset mid-RUN or mid-DONE aborts silently; the partial result is discarded.
- States: IDLE, RUN, DONE.
- in_ready is combinational: 1 in IDLE; 1 in DONE when out_ready=1; 0 in RUN.
- Accept = in_valid & in_ready. On accept:
  - latch a, and b XOR {W{sub}};
  - carry reg <= cin ^ sub;
  - counter <= 0;
  - sum <= 0;
  - state <= RUN.
- RUN, counter value k (0..WORDS−1):
  - adder inputs are word k of latched a, word k of latched b_eff, and the carry reg;
  - at the edge: sum word k <= adder Sum; carry reg <= adder Cout; counter increments.
  - When k = WORDS−1: cout <= adder Cout; ovf <= (a[W−1]==b_eff[W−1]) & (Sum[N−1]!=a[W−1]); state <= DONE.
- Latency: out_valid rises exactly WORDS clocks after the accept edge. WORDS=1 gives 1 clock.
- DONE: out_valid=1. sum/cout/ovf are stable until the handshake completes.
  - out_ready=1, in_valid=0: state <= IDLE, out_valid <= 0.
  - out_ready=1, in_valid=1: back-to-back. Result retires and the new command is accepted in the same edge; state <= RUN, out_valid <= 0.
  - out_ready=0: hold everything; in_valid is ignored.
- in_valid during RUN is ignored; the command is not captured.
- Operand inputs are sampled only at accept. Later changes to a/b/sub/cin have no effect on the current operation.
- Counter width: $clog2(WORDS), minimum 1 bit. The counter never exceeds WORDS−1; no wrap beyond the terminal value.
- sum words not yet written during RUN read as 0. sum is not a consumer-visible value until out_valid.

Optional Feature:
- Macro MP_ADD_ZERO_FLAG_EN.
- Defined: adds output port zero (1 bit). Registered with cout/ovf at the last word. zero=1 iff the complete W-bit sum is 0. Held through DONE; reset value 0.
- Not defined: no zero port and no associated logic. All other behaviour is identical.

Test Plan (N=4, WORDS=4, W=16):
- Reset then idle: rst held 2 cycles -> out_valid=0, sum=0x0000, cout=0, ovf=0, in_ready=1 after release.
- Add: a=0x1234, b=0x0FFF, sub=0, cin=0 -> after exactly 4 clocks out_valid=1, sum=0x2233, cout=0, ovf=0. in_ready=0 during the 4 RUN cycles.
- Carry chain across all words: a=0xFFFF, b=0x0001, add -> sum=0x0000, cout=1, ovf=0, zero=1 (when MP_ADD_ZERO_FLAG_EN).
  - Also a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=0 -> sum=0xFFFE, cout=0. Then cin=1 -> sum=0xFFFD.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs stable, new in_valid ignored.
  - Then out_ready=1 with in_valid=1 (a=0x0001, b=0x0002) -> same-edge accept; the next result 0x0003 appears 4 clocks later.
- Reset mid-RUN: assert rst after 2 words of a=0xAAAA+b=0x5555 -> IDLE, sum=0, out_valid never rises for the aborted op. A following 0x0001+0x0001 yields 0x0002.

Source files
------------

// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-precision add/sub over one N-bit ripple adder, LSW first; define MP_ADD_ZERO_FLAG_EN to add the zero flag output.
module mp_add_seq #(
  parameter int N     = 4,
  parameter int WORDS = 4,
  localparam int W    = N * WORDS,
  localparam int CW   = WORDS > 1 ? $clog2(WORDS) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
`ifdef MP_ADD_ZERO_FLAG_EN
  ,
  output logic         zero
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;
  logic [W-1:0] a_q, b_q, sum_n;
  logic [CW-1:0] cnt;
  logic cy, accept, last;
  logic [N-1:0] aw, bw, s;
  logic [N:0] c;
  assign in_ready  = state == IDLE || (state == DONE && out_ready);
  assign out_valid = state == DONE;
  assign accept    = in_valid && in_ready;
  assign last      = cnt == CW'(WORDS - 1);
  assign aw        = a_q[cnt*N +: N];
  assign bw        = b_q[cnt*N +: N];
  assign c[0]      = cy;
  for (genvar i = 0; i < N; i++) begin : g_rca
    assign s[i]   = aw[i] ^ bw[i] ^ c[i];
    assign c[i+1] = (aw[i] & bw[i]) | (c[i] & (aw[i] ^ bw[i]));
  end
  always_comb begin
    sum_n = sum;
    sum_n[cnt*N +: N] = s;
  end
  always_comb begin
    nxt = accept ? RUN
        : state == RUN ? (last ? DONE : RUN)
        : (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  // b is stored pre-inverted for subtract, so ovf compares against the effective operand
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      cnt  <= '0;
      cy   <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
`ifdef MP_ADD_ZERO_FLAG_EN
      zero <= 1'b0;
`endif
    end else if (accept) begin
      a_q <= a;
      b_q <= b ^ {W{sub}};
      cy  <= cin ^ sub;
      cnt <= '0;
      sum <= '0;
    end else if (state == RUN) begin
      sum <= sum_n;
      cy  <= c[N];
      cnt <= last ? cnt : cnt + 1'b1;
      if (last) begin
        cout <= c[N];
        ovf  <= (a_q[W-1] == b_q[W-1]) && (s[N-1] != a_q[W-1]);
`ifdef MP_ADD_ZERO_FLAG_EN
        zero <= ~|sum_n;
`endif
      end
    end
  end
endmodule

// File: tb/tb_mp_add_seq.sv
// tb_mp_add_seq: directed plus randomized checks of mp_add_seq against an arithmetic reference model.
module tb_mp_add_seq;
  localparam int N = 4, WORDS = 4, W = 16;
  logic clk = 0, rst = 1, in_valid = 0, sub = 0, cin = 0, out_ready = 0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, cout, ovf;
  logic [W-1:0] sum;
`ifdef MP_ADD_ZERO_FLAG_EN
  logic zero;
`endif
  int n_chk = 0, n_pass = 0;
  mp_add_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
`ifdef MP_ADD_ZERO_FLAG_EN
    , .zero(zero)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // {ovf, cout, sum} from integer arithmetic
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic s, input logic c);
    logic [15:0] r;
    logic co;
    int v;
    r  = s ? x - y - 16'(c) : x + y + 16'(c);
    co = s ? (int'(x) >= int'(y) + int'(c)) : (int'(x) + int'(y) + int'(c) > 65535);
    v  = s ? int'($signed(x)) - int'($signed(y)) - int'(c)
           : int'($signed(x)) + int'($signed(y)) + int'(c);
    return {(v > 32767 || v < -32768), co, r};
  endfunction
  task automatic start(input logic [15:0] x, input logic [15:0] y, input logic s, input logic c);
    in_valid = 1; a = x; b = y; sub = s; cin = c;
    tick();
    out_ready = 0;
    in_valid = 1'($urandom);
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
  endtask
  task automatic expect_res(input string tag, input logic [15:0] x, input logic [15:0] y, input logic s, input logic c);
    logic [17:0] m;
    m = model(x, y, s, c);
    check({tag, " valid"}, 32'(out_valid), 1);
    check({tag, " sum"}, 32'(sum), 32'(m[15:0]));
    check({tag, " cout"}, 32'(cout), 32'(m[16]));
    check({tag, " ovf"}, 32'(ovf), 32'(m[17]));
`ifdef MP_ADD_ZERO_FLAG_EN
    check({tag, " zero"}, 32'(zero), 32'(m[15:0] == 16'h0));
`endif
  endtask
  task automatic wait_res(input string tag, input logic [15:0] x, input logic [15:0] y, input logic s, input logic c);
    for (int j = 0; j < WORDS; j++) begin
      check({tag, " busy"}, {30'b0, out_valid, in_ready}, 0);
      in_valid = 1'($urandom);
      a = 16'($urandom);
      tick();
    end
    expect_res(tag, x, y, s, c);
  endtask
  task automatic retire;
    in_valid = 0;
    out_ready = 1;
    #1 check("ready_in_done", 32'(in_ready), 1);
    tick();
    out_ready = 0;
    check("retired", 32'(out_valid), 0);
  endtask
  task automatic op(input string tag, input logic [15:0] x, input logic [15:0] y, input logic s, input logic c);
    start(x, y, s, c);
    wait_res(tag, x, y, s, c);
    retire();
  endtask
  initial begin
    tick(); tick();
    rst = 0;
    #1;
    check("rst valid", 32'(out_valid), 0);
    check("rst sum", 32'(sum), 0);
    check("rst cout", 32'(cout), 0);
    check("rst ovf", 32'(ovf), 0);
    check("rst ready", 32'(in_ready), 1);
    op("add", 16'h1234, 16'h0FFF, 0, 0);
    op("carry", 16'hFFFF, 16'h0001, 0, 0);
    op("ovf", 16'h7FFF, 16'h0001, 0, 0);
    op("sub", 16'h0005, 16'h0007, 1, 0);
    start(16'h0005, 16'h0007, 1, 1);
    wait_res("subb", 16'h0005, 16'h0007, 1, 1);
    for (int j = 0; j < 5; j++) begin
      in_valid = 1; a = 16'($urandom); b = 16'($urandom);
      tick();
      check("hold ready", 32'(in_ready), 0);
      expect_res("hold", 16'h0005, 16'h0007, 1, 1);
    end
    out_ready = 1;
    start(16'h0001, 16'h0002, 0, 0);
    wait_res("b2b", 16'h0001, 16'h0002, 0, 0);
    retire();
    start(16'hAAAA, 16'h5555, 0, 0);
    tick(); tick();
    in_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    check("abort sum", 32'(sum), 0);
    for (int j = 0; j < 6; j++) begin
      check("abort valid", 32'(out_valid), 0);
      tick();
    end
    op("after_abort", 16'h0001, 16'h0001, 0, 0);
    for (int i = 0; i < 40; i++) begin
      logic [15:0] x, y;
      logic s, c;
      x = 16'($urandom); y = 16'($urandom); s = 1'($urandom); c = 1'($urandom);
      if (i % 8 == 0) y = ~x;
      start(x, y, s, c);
      wait_res("rand", x, y, s, c);
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        tick();
        expect_res("rand_hold", x, y, s, c);
      end
      retire();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
